// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    DATA,
    PARITY,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  // bit0..bit7, parity, stop, device ack
  localparam int PS2_FRAME_EDGES = 11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // Extra attempts after the first failure when retry is built in.
  localparam int MAX_RETRIES = 2;

  // Odd parity: the frame carries an odd number of ones over data + parity.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a client and the PS/2 host transmitter.
// valid/ready: a byte transfers on a clock edge where tx_valid && tx_ready;
// tx_data must be stable while tx_valid is high; tx_valid is ignored while busy.
// tx_done/tx_err are single-cycle pulses; state is the live FSM state.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  ps2_state_e state;

  modport master (output tx_data, tx_valid,
                  input  tx_ready, busy, tx_done, tx_err, state);
  modport slave  (input  tx_data, tx_valid,
                  output tx_ready, busy, tx_done, tx_err, state);
endinterface

// File: rtl/ps2_host_tx_sync_edge.sv
// Multi-stage synchronizer for one PS/2 line plus a falling-edge detector.
// Idle PS/2 lines are high, so the chain resets to ones.
module ps2_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw pin through the chain and remember the last synced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d_i);
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign fall_o = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends a start bit, then
// shifts data/parity/stop on device clock falling edges and checks the ACK.
// Build option PS2_TX_RETRY_EN: a NACK or timeout restarts the frame with the
// same byte up to two more times before reporting the error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int INHIBIT_CYCLES = CLK_HZ / 10_000,
  parameter int TIMEOUT_CYCLES = (CLK_HZ / 1000) * 15,
  parameter int SYNC_STAGES    = 2
) (
  input  logic           clk,
  input  logic           rst,
  ps2_host_tx_if.slave   bus,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e       state_q, state_d;
  logic [8:0]       frame_q, frame_d;   // {parity, data}, indexed LSB first
  logic [3:0]       bit_q, bit_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             data_oe_q, data_oe_d;
  logic             err_pend_q, err_pend_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             finish, fail;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  logic clk_s, clk_fall, data_s;

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk(clk), .rst(rst), .d_i(ps2_clk_in), .q_o(clk_s), .fall_o(clk_fall)
  );

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_data_sync (
    .clk(clk), .rst(rst), .d_i(ps2_data_in), .q_o(data_s), .fall_o()
  );

  // State and datapath registers; reset releases both bus lines at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      bit_q      <= '0;
      inh_q      <= '0;
      tmo_q      <= '0;
      data_oe_q  <= 1'b0;
      err_pend_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_q      <= bit_d;
      inh_q      <= inh_d;
      tmo_q      <= tmo_d;
      data_oe_q  <= data_oe_d;
      err_pend_q <= err_pend_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  // Next-state logic; timeout is applied after the per-state actions so it wins.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_d      = bit_q;
    inh_d      = inh_q;
    tmo_d      = '0;
    data_oe_d  = data_oe_q;
    err_pend_d = err_pend_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    finish     = 1'b0;
    fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d    = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.tx_valid) begin
          state_d    = INHIBIT;
          frame_d    = {odd_parity(bus.tx_data), bus.tx_data};
          inh_d      = '0;
          err_pend_d = 1'b0;
          data_oe_d  = 1'b0;
`ifdef PS2_TX_RETRY_EN
          retry_d    = '0;
`endif
        end
      end
      INHIBIT: begin
        inh_d = inh_q + 1'b1;
        if (inh_q == INH_LAST) begin
          data_oe_d = 1'b1;           // start bit
          state_d   = START;
        end
      end
      START: begin
        tmo_d = tmo_q + 1'b1;
        if (clk_fall) begin
          data_oe_d = ~frame_q[0];
          bit_d     = 4'd1;
          state_d   = DATA;
        end
      end
      DATA: begin
        tmo_d = tmo_q + 1'b1;
        if (clk_fall) begin
          data_oe_d = ~frame_q[bit_q];
          if (bit_q == 4'd8) state_d = PARITY;
          else               bit_d   = bit_q + 4'd1;
        end
      end
      PARITY: begin
        tmo_d = tmo_q + 1'b1;
        if (clk_fall) begin
          data_oe_d = 1'b0;           // stop bit: release the line
          state_d   = ACK;
        end
      end
      ACK: begin
        tmo_d = tmo_q + 1'b1;
        if (clk_fall) begin
          err_pend_d = data_s;        // device pulls data low to acknowledge
          state_d    = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        tmo_d = tmo_q + 1'b1;
        if (clk_s && data_s) begin
          finish = 1'b1;
          fail   = err_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q inside {START, DATA, PARITY, ACK, WAIT_IDLE}) && (tmo_q == TMO_LAST)) begin
      finish = 1'b1;
      fail   = 1'b1;
    end

    if (finish) begin
`ifdef PS2_TX_RETRY_EN
      if (fail && (retry_q != 2'(MAX_RETRIES))) begin
        retry_d    = retry_q + 2'd1;
        state_d    = INHIBIT;
        inh_d      = '0;
        data_oe_d  = 1'b0;
        err_pend_d = 1'b0;
      end else
`endif
      begin
        state_d   = IDLE;
        data_oe_d = 1'b0;
        done_d    = 1'b1;
        err_d     = fail;
      end
    end
  end

  assign ps2_clk_oe   = (state_q == INHIBIT);
  assign ps2_data_oe  = data_oe_q | ((state_q == INHIBIT) && (inh_q == INH_LAST));
  assign bus.tx_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.tx_done  = done_q;
  assign bus.tx_err   = err_q;
  assign bus.state    = state_q;

endmodule
